fp_dot_acc: RTL and testbench
=============================

// Module: fp_dot_acc
// PURPOSE
//  Streaming fixed-point dot-product engine; consumes rounded Qm.f products from fp_mult.
//  - Accepts len operand pairs over valid/ready and registers each product.
//  - Sums products in a guard-bit accumulator.
//  - Returns one saturated n-bit result over valid/ready.
//  - Sits beside the NISC datapath as a multi-cycle vector/filter-tap unit.
// PARAMETERS
//  n      8   operand/result width (signed two's complement)
//  f      7   fractional bits (default Q1.7)
//  LEN_W  8   width of len port; max vector length 2**LEN_W-1
//  G      4   accumulator guard bits; accumulator width n+G
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      begin a new dot product (sampled in IDLE only)
//  len        in   LEN_W  number of pairs, captured with start
//  in_valid   in   1      a/b pair valid
//  in_ready   out  1      engine accepts pair this cycle
//  a, b       in   n      signed operands
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  n      saturated signed dot product
//  overflow   out  1      sticky per job; valid with out_valid
//  busy       out  1      high in any state except IDLE
// BEHAVIOUR
//  Reset and async values: state=IDLE; in_ready, out_valid, overflow, busy, result = 0; accumulator, count, product register = 0.
//  Transfer rules:
//   - Input transfer: in_valid && in_ready.
//   - Output transfer: out_valid && out_ready.
//  FSM:
//   - IDLE: start -> clear acc/count/overflow, latch len. len==0 -> DONE; else ACCUM.
//   - ACCUM: in_ready=1.
//     * Each input transfer: p_reg <= fp_mult(a,b), p_vld <= 1, count++.
//     * p_vld: acc <= sat_{n+G}(acc + sext(p_reg)).
//     * Transfer with count==len-1 -> DRAIN; in_ready drops the next cycle.
//   - DRAIN: add final p_reg; register result <= sat_n(acc_next). Then -> DONE.
//   - DONE: out_valid=1; result and overflow stable. Output transfer -> IDLE.
//  Latency: last input transfer -> out_valid is 2 cycles. start with len==0 -> out_valid 1 cycle later, result=0.
//  Throughput: one pair per cycle; in_valid gaps only stall.
//  start outside IDLE is ignored; len is not re-sampled.
//  Product corner case:
//   - a==b==-2**(n-1) with f==n-1: fp_mult wraps to MIN.
//   - Engine substitutes MAX (2**(n-1)-1) and sets overflow.
//  Saturation (sets overflow):
//   - Accumulator clamps at +/-2**(n+G-1) bounds.
//   - Final result clamps to [-2**(n-1), 2**(n-1)-1].
//  Arithmetic: products sign-extended to n+G; no rounding beyond fp_mult's own.
//  Async reset mid-job: all outputs to reset values immediately; the partial job is discarded.
// STRUCTURE
//  Shared package fp_pkg:
//   - dot_state_t enum {IDLE, ACCUM, DRAIN, DONE}
//   - functions sat_to(width) and MIN/MAX constants, parameterised by n
//  Sub-module: one fp_mult #(.n(n),.f(f)), combinational, feeding p_reg.
//  Rest: FSM, len counter, accumulator, result register.
// TESTING (defaults n=8 f=7 G=4)
//  1. len=3: (0x40,0x40),(0x20,0x40),(0xC0,0x40) back-to-back
//     -> result=0x10, overflow=0, out_valid 2 cycles after 3rd transfer.
//  2. len=4: four (0x40,0x40)
//     -> sum 0x80 exceeds range -> result=0x7F, overflow=1.
//  3. len=1: (0x80,0x80)
//     -> result=0x7F, overflow=1. len=1: (0x01,0x40) -> result=0x01 (rounding).
//  4. len=0 start -> out_valid next cycle, result=0x00, no in_ready.
//     start pulsed during ACCUM -> ignored.
//  5. Backpressure:
//     - len=2, in_valid gaps of 3 cycles -> count advances only on transfers.
//     - out_ready low 5 cycles -> result/out_valid held, busy=1.
//  6. rst asserted mid-ACCUM after 1 of 3 pairs
//     -> outputs 0 same cycle. New job len=1 (0x40,0x40) -> result=0x20, overflow=0.

Source files
------------

// File: rtl/fp_pkg.sv
// ----------------------------------------------------------------------------
// fp_pkg
// Shared types and helpers for the fixed-point dot-product engine.
//   dot_state_t : engine FSM states
//   max_of(w)   : largest signed value representable in w bits
//   min_of(w)   : smallest signed value representable in w bits
//   sat_to(v,w) : clamp a wide signed value into the signed w-bit range
//   sat_hit(v,w): 1 when sat_to(v,w) had to clamp
// All helpers work on 64-bit signed values so that any operand/accumulator
// width up to 63 bits can share them.
// ----------------------------------------------------------------------------
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } dot_state_t;

   function automatic logic signed [63:0] max_of(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] min_of(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                 input int w);
      if (v > max_of(w)) return max_of(w);
      if (v < min_of(w)) return min_of(w);
      return v;
   endfunction

   function automatic logic sat_hit(input logic signed [63:0] v, input int w);
      return (v > max_of(w)) || (v < min_of(w));
   endfunction

endpackage

// File: rtl/fp_mult.sv
// ----------------------------------------------------------------------------
// fp_mult
// Combinational signed Qm.f multiplier with round-half-up.
//   a, b : signed n-bit operands, f fractional bits
//   p    : signed n-bit product, (a*b + 2**(f-1)) >>> f, wrapped to n bits
// The wrap is intentional: the only case that leaves the range at the
// default format is MIN*MIN, which the caller detects and replaces.
// ----------------------------------------------------------------------------
module fp_mult #(
   parameter int n = 8,
   parameter int f = 7
) (
   input  logic signed [n-1:0] a,
   input  logic signed [n-1:0] b,
   output logic signed [n-1:0] p
);

   localparam logic signed [2*n-1:0] HALF =
      (f > 0) ? ((2*n)'(1) <<< (f - 1)) : '0;

   logic signed [2*n-1:0] full;
   logic signed [2*n-1:0] rounded;

   always_comb begin
      full    = a * b;
      rounded = (full + HALF) >>> f;
      p       = n'(rounded);
   end

endmodule

// File: rtl/fp_dot_acc.sv
// ----------------------------------------------------------------------------
// fp_dot_acc
// Streaming fixed-point dot-product engine.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   start, len : begin a job of len pairs (sampled in IDLE only)
//   in_valid/in_ready, a, b : operand pair stream
//   out_valid/out_ready, result, overflow : one saturated result per job
//   busy       : high in every state except IDLE
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. A source holds valid and its payload until that edge; ready never
// depends on valid combinationally. out_valid, result and overflow stay put
// until the result beat is taken.
// Pipeline: each accepted pair is multiplied into p_reg, and p_reg is added
// into the guard-bit accumulator the following cycle. DRAIN folds in the
// last product and registers the clamped result, giving a 2-cycle latency
// from the last input beat to out_valid.
// ----------------------------------------------------------------------------
module fp_dot_acc
   import fp_pkg::*;
#(
   parameter int n     = 8,
   parameter int f     = 7,
   parameter int LEN_W = 8,
   parameter int G     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [n-1:0]  a,
   input  logic signed [n-1:0]  b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [n-1:0]  result,
   output logic                 overflow,
   output logic                 busy
);

   localparam int ACC_W = n + G;
   localparam logic signed [n-1:0] MAX_N = n'(max_of(n));
   localparam logic signed [n-1:0] MIN_N = n'(min_of(n));

   dot_state_t state, state_next;

   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        count;
   logic signed [ACC_W-1:0] acc;
   logic signed [n-1:0]     p_reg;
   logic                    p_vld;

   logic signed [n-1:0]     mult_p;
   logic signed [n-1:0]     p_in;
   logic                    corner;
   logic                    in_xfer;
   logic                    out_xfer;
   logic                    last_xfer;

   logic signed [63:0]      acc_sum;
   logic signed [ACC_W-1:0] acc_next;
   logic                    acc_clamp;
   logic signed [n-1:0]     res_next;
   logic                    res_clamp;

   fp_mult #(.n(n), .f(f)) u_mult (
      .a (a),
      .b (b),
      .p (mult_p)
   );

   // MIN*MIN in Q1.(n-1) is +1.0, which fp_mult wraps back to MIN; replace
   // it with the closest representable value and flag it.
   always_comb begin
      corner = (a == MIN_N) && (b == MIN_N) && (f == n - 1);
      p_in   = corner ? MAX_N : mult_p;
   end

   always_comb begin
      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      last_xfer = in_xfer && (count == len_q - 1'b1);
   end

   // Accumulator add and both saturation stages.
   always_comb begin
      acc_sum   = 64'($signed(acc)) + (p_vld ? 64'($signed(p_reg)) : 64'sd0);
      acc_next  = ACC_W'(sat_to(acc_sum, ACC_W));
      acc_clamp = sat_hit(acc_sum, ACC_W);
      res_next  = n'(sat_to(64'($signed(acc_next)), n));
      res_clamp = sat_hit(64'($signed(acc_next)), n);
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = (len == '0) ? DONE : ACCUM;
         ACCUM: if (last_xfer) state_next = DRAIN;
         DRAIN: state_next = DONE;
         DONE:  if (out_xfer) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM: outputs (state-decoded, so reset clears them immediately)
   always_comb begin
      in_ready  = (state == ACCUM);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Datapath: length counter, product register, accumulator, result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q    <= '0;
         count    <= '0;
         acc      <= '0;
         p_reg    <= '0;
         p_vld    <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               p_vld <= 1'b0;
               if (start) begin
                  len_q    <= len;
                  count    <= '0;
                  acc      <= '0;
                  result   <= '0;
                  overflow <= 1'b0;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               if (p_vld && acc_clamp) overflow <= 1'b1;
               if (in_xfer) begin
                  p_reg <= p_in;
                  p_vld <= 1'b1;
                  count <= count + 1'b1;
                  if (corner) overflow <= 1'b1;
               end else begin
                  p_vld <= 1'b0;
               end
            end
            DRAIN: begin
               acc    <= acc_next;
               result <= res_next;
               p_vld  <= 1'b0;
               if (acc_clamp || res_clamp) overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_dot_acc.sv
// ----------------------------------------------------------------------------
// tb_fp_dot_acc
// Directed bench for fp_dot_acc (n=8, f=7, LEN_W=8, G=4). A job model
// computes {overflow,result} from the operand list with plain integer
// arithmetic; a compare process checks every cycle out_valid is high.
// ----------------------------------------------------------------------------
module tb_fp_dot_acc;

   localparam int N = 8;
   localparam int F = 7;
   localparam int LEN_W = 8;
   localparam int G = 4;

   logic              clk;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic              in_ready;
   logic signed [N-1:0] a;
   logic signed [N-1:0] b;
   logic              out_valid;
   logic              out_ready;
   logic signed [N-1:0] result;
   logic              overflow;
   logic              busy;

   fp_dot_acc #(.n(N), .f(F), .LEN_W(LEN_W), .G(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [7:0] va[64];
   logic [7:0] vb[64];

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   // Rounded Q1.7 product; MIN*MIN becomes +127 with overflow.
   function automatic int model_prod(input int x, input int y, output bit ov);
      int p;
      ov = 1'b0;
      if (x == -128 && y == -128) begin
         ov = 1'b1;
         return 127;
      end
      p = x * y + 64;
      p = p >>> 7;
      p = ((p + 128) & 255) - 128;
      return p;
   endfunction

   function automatic logic [8:0] model_job(input int cnt);
      int acc = 0;
      bit ov = 1'b0;
      bit pov;
      int p;
      for (int i = 0; i < cnt; i++) begin
         p = model_prod(int'($signed(va[i])), int'($signed(vb[i])), pov);
         if (pov) ov = 1'b1;
         acc = acc + p;
         if (acc > 2047)  begin acc = 2047;  ov = 1'b1; end
         if (acc < -2048) begin acc = -2048; ov = 1'b1; end
      end
      if (acc > 127)  begin acc = 127;  ov = 1'b1; end
      if (acc < -128) begin acc = -128; ov = 1'b1; end
      return {ov, 8'(acc)};
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("sb_result", 32'({overflow, result}), 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(input int l, output int c_at);
      start = 1'b1;
      len   = LEN_W'(l);
      c_at  = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_pair(input int i, input int gaps, input bit poke,
                            output int c_at);
      int t;
      for (int g = 0; g < gaps; g++) begin
         in_valid = 1'b0;
         if (poke && g == 0) begin
            start = 1'b1;
            len   = 8'd5;
         end
         @(posedge clk); #1;
         start = 1'b0;
         check("in_ready_held_in_gap", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      c_at = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run_job(input string nm, input int l, input int gaps,
                          input int hold, input bit poke,
                          input logic [8:0] exp_lit);
      int c_ref, t, lat;
      check({nm, "_model"}, 32'(model_job(l)), 32'(exp_lit));
      exp_q.push_back(model_job(l));
      do_start(l, c_ref);
      if (l == 0) check({nm, "_no_in_ready"}, 32'(in_ready), 32'd0);
      for (int i = 0; i < l; i++)
         send_pair(i, (i == 0) ? 0 : gaps, poke && (i == 1), c_ref);
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!out_valid) check({nm, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
      lat = cyc - c_ref;
      check({nm, "_latency"}, 32'(lat), (l == 0) ? 32'd1 : 32'd2);
      check({nm, "_result"}, 32'({overflow, result}), 32'(exp_lit));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({nm, "_hold_valid"}, 32'({out_valid, busy}), 32'b11);
         check({nm, "_hold_result"}, 32'({overflow, result}), 32'(exp_lit));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({nm, "_back_idle"}, 32'({out_valid, busy}), 32'b00);
   endtask

   task automatic set_pair(input int i, input logic [7:0] x, input logic [7:0] y);
      va[i] = x;
      vb[i] = y;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c_dummy;
      rst = 1'b1;
      start = 1'b0;
      len = '0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      out_ready = 1'b0;
      #1;
      check("reset_outputs", 32'({in_ready, out_valid, overflow, busy, result}), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // len=3 back-to-back: 32 + 16 - 32 = 16
      set_pair(0, 8'h40, 8'h40);
      set_pair(1, 8'h20, 8'h40);
      set_pair(2, 8'hC0, 8'h40);
      run_job("t1_len3", 3, 0, 0, 1'b0, 9'h010);

      // four 0.25 products sum to 1.0 -> clamp
      for (int i = 0; i < 4; i++) set_pair(i, 8'h40, 8'h40);
      run_job("t2_sat", 4, 0, 0, 1'b0, 9'h17F);

      // MIN*MIN corner, then rounding of 1/128 * 0.5
      set_pair(0, 8'h80, 8'h80);
      run_job("t3_minmin", 1, 0, 0, 1'b0, 9'h17F);
      set_pair(0, 8'h01, 8'h40);
      run_job("t3_round", 1, 0, 0, 1'b0, 9'h001);

      // empty job
      run_job("t4_len0", 0, 0, 0, 1'b0, 9'h000);

      // start pulsed mid-ACCUM must be ignored (len stays 2)
      set_pair(0, 8'h40, 8'h40);
      set_pair(1, 8'h20, 8'h40);
      run_job("t4_start_ignored", 2, 1, 0, 1'b0 | 1'b1, 9'h030);

      // input gaps and output backpressure
      set_pair(0, 8'hC0, 8'h40);
      set_pair(1, 8'hC0, 8'h40);
      run_job("t5_gaps", 2, 3, 0, 1'b0, 9'h0C0);
      set_pair(0, 8'h20, 8'h40);
      run_job("t5_backpressure", 1, 0, 5, 1'b0, 9'h010);

      // negative final clamp: 5 * -127
      for (int i = 0; i < 5; i++) set_pair(i, 8'h80, 8'h7F);
      run_job("neg_sat", 5, 0, 0, 1'b0, 9'h180);

      // accumulator clamp: 20 * 126 exceeds 2047
      for (int i = 0; i < 20; i++) set_pair(i, 8'h7F, 8'h7F);
      run_job("acc_sat", 20, 0, 0, 1'b0, 9'h17F);

      // async reset after 1 of 3 pairs
      set_pair(0, 8'h40, 8'h40);
      do_start(3, c_dummy);
      send_pair(0, 0, 1'b0, c_dummy);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs",
            32'({in_ready, out_valid, overflow, busy, result}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      set_pair(0, 8'h40, 8'h40);
      run_job("t6_after_reset", 1, 0, 0, 1'b0, 9'h020);

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
